// File: rtl/seq_alu.sv
// Multi-cycle datapath ALU for the miniSRC CPU: single-cycle logic/shift ops,
// radix-2 Booth signed multiply and restoring signed divide, start/done handshake.
module seq_alu #(
  parameter int W   = 32,
  parameter int SHW = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] zhi,
  output logic [W-1:0] zlo,
  output logic         div0
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_NEG  = 4'd12;

  localparam logic [SHW-1:0] CNT_INIT = SHW'(W - 1);

  function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
    return x[W-1] ? (W'(0) - x) : x;
  endfunction

  state_e         state_q, state_d;
  // hi_q is one bit wider than W so Booth partial sums never overflow (a = -2^(W-1))
  logic [W:0]     hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;
  logic           qm1_q, qm1_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   zhi_q, zhi_d, zlo_q, zlo_d;
  logic           div0_q, div0_d, busy_q, busy_d, done_q, done_d;

  logic           accept_s;
  logic [SHW-1:0] amt_s, neg_amt_s;
  logic [W:0]     add_s, sub_s, a_ext_s, booth_sum_s, rem_sh_s, ub_ext_s;
  logic [W-1:0]   sc_hi_s, sc_lo_s, booth_lo_s, div_lo_s, ub_s;
  logic [W:0]     booth_hi_s, div_hi_s;

  assign accept_s = start && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          if (op == OP_MUL) begin
            state_d = S_MUL;
          end else if ((op == OP_DIV) && (b != '0)) begin
            state_d = S_DIV;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             state_d = S_MUL;
      end
      S_DIV: begin
        if (cnt_q == '0) state_d = S_FIX;
        else             state_d = S_DIV;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the upcoming state.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_comb begin
    amt_s     = b[SHW-1:0];
    neg_amt_s = SHW'(0) - amt_s;
    add_s     = {1'b0, a} + {1'b0, b};
    sub_s     = {1'b0, a} - {1'b0, b};
    sc_hi_s   = '0;
    sc_lo_s   = '0;
    case (op)
      OP_ADD: begin
        sc_lo_s = add_s[W-1:0];
        sc_hi_s = {{(W-1){1'b0}}, add_s[W]};
      end
      OP_SUB: begin
        sc_lo_s = sub_s[W-1:0];
        sc_hi_s = {{(W-1){1'b0}}, sub_s[W]};
      end
      OP_SHR:  sc_lo_s = a >> amt_s;
      OP_SHRA: sc_lo_s = $signed(a) >>> amt_s;
      OP_SHL:  sc_lo_s = a << amt_s;
      // neg_amt_s wraps to 0 for amount 0, so the OR collapses to a itself.
      OP_ROR:  sc_lo_s = (a >> amt_s) | (a << neg_amt_s);
      OP_ROL:  sc_lo_s = (a << amt_s) | (a >> neg_amt_s);
      OP_AND:  sc_lo_s = a & b;
      OP_OR:   sc_lo_s = a | b;
      OP_NOT:  sc_lo_s = ~a;
      OP_NEG:  sc_lo_s = W'(0) - a;
      default: sc_lo_s = '0;
    endcase
  end

  always_comb begin
    a_ext_s = {a_q[W-1], a_q};
    case ({lo_q[0], qm1_q})
      2'b01:   booth_sum_s = hi_q + a_ext_s;
      2'b10:   booth_sum_s = hi_q - a_ext_s;
      default: booth_sum_s = hi_q;
    endcase
    booth_hi_s = {booth_sum_s[W], booth_sum_s[W:1]};
    booth_lo_s = {booth_sum_s[0], lo_q[W-1:1]};
  end

  // Restoring divide step: remainder in hi_q, dividend shifts out of lo_q as quotient shifts in.
  always_comb begin
    ub_s     = abs_w(b_q);
    ub_ext_s = {1'b0, ub_s};
    rem_sh_s = {hi_q[W-1:0], lo_q[W-1]};
    if (rem_sh_s >= ub_ext_s) begin
      div_hi_s = rem_sh_s - ub_ext_s;
      div_lo_s = {lo_q[W-2:0], 1'b1};
    end else begin
      div_hi_s = rem_sh_s;
      div_lo_s = {lo_q[W-2:0], 1'b0};
    end
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    qm1_d  = qm1_q;
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    zhi_d  = zhi_q;
    zlo_d  = zlo_q;
    div0_d = div0_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          a_d    = a;
          b_d    = b;
          cnt_d  = CNT_INIT;
          div0_d = 1'b0;
          if (op == OP_MUL) begin
            hi_d  = '0;
            lo_d  = b;
            qm1_d = 1'b0;
          end else if (op == OP_DIV) begin
            if (b == '0) begin
              zlo_d  = '1;
              zhi_d  = a;
              div0_d = 1'b1;
            end else begin
              hi_d = '0;
              lo_d = abs_w(a);
            end
          end else begin
            zhi_d = sc_hi_s;
            zlo_d = sc_lo_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_MUL: begin
        hi_d  = booth_hi_s;
        lo_d  = booth_lo_s;
        qm1_d = lo_q[0];
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          zhi_d = booth_hi_s[W-1:0];
          zlo_d = booth_lo_s;
        end else begin
          zhi_d = zhi_q;
        end
      end
      S_DIV: begin
        hi_d  = div_hi_s;
        lo_d  = div_lo_s;
        cnt_d = cnt_q - SHW'(1);
      end
      S_FIX: begin
        zlo_d = (a_q[W-1] ^ b_q[W-1]) ? (W'(0) - lo_q) : lo_q;
        zhi_d = a_q[W-1] ? (W'(0) - hi_q[W-1:0]) : hi_q[W-1:0];
      end
      S_DONE:  cnt_d = cnt_q;
      default: cnt_d = cnt_q;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign zhi  = zhi_q;
  assign zlo  = zlo_q;
  assign div0 = div0_q;

endmodule
